// File: rtl/mp_sram_arbiter.sv
// mp_sram_arbiter: time-shares one async SRAM among NUM_PORTS clients via TDM or round-robin
module mp_sram_arbiter #(
  parameter int NUM_PORTS     = 2,
  parameter int ADDR_W        = 16,
  parameter int DATA_W        = 8,
  parameter int ACCESS_CYCLES = 1,
  parameter int ARB_MODE      = 0
) (
  input  logic                          memClk,
  input  logic                          sysRst,
  output logic [ADDR_W-1:0]             memAddr,
  inout  wire  [DATA_W-1:0]             memData,
  output logic                          memReN,
  output logic                          memWeN,
  input  logic [NUM_PORTS-1:0]          portReq,
  input  logic [NUM_PORTS-1:0]          portWe,
  input  logic [NUM_PORTS*ADDR_W-1:0]   portAddr,
  input  logic [NUM_PORTS*DATA_W-1:0]   portWData,
  output logic [NUM_PORTS-1:0]          portAck,
  output logic [NUM_PORTS-1:0]          portRValid,
  output logic [NUM_PORTS*DATA_W-1:0]   portRData
);
  localparam int PW = $clog2(NUM_PORTS);
  typedef enum logic [1:0] {IDLE, ADDR, STROBE, RECOVER} state_t;
  state_t                     state_q, state_d;
  logic [3:0]                 cnt_q, cnt_d;
  logic [PW-1:0]              slot_q, slot_d, ptr_q, ptr_d, g_q, g_d;
  logic                       act_q, act_d, we_q, we_d;
  logic [ADDR_W-1:0]          addr_q, addr_d;
  logic [DATA_W-1:0]          wdata_q, wdata_d;
  logic [NUM_PORTS*DATA_W-1:0] rdata_q, rdata_d;
  logic [PW-1:0]              rr_sel, idx, sel;
  logic                       rr_vld, go, grant;
  // round-robin search from ptr+1 with wrap; lowest offset wins
  always_comb begin
    rr_sel = ptr_q;
    rr_vld = 1'b0;
    idx    = ptr_q;
    for (int i = NUM_PORTS; i >= 1; i--) begin
      idx = PW'((int'(ptr_q) + i) % NUM_PORTS);
      if (portReq[idx]) begin
        rr_sel = idx;
        rr_vld = 1'b1;
      end
    end
    sel   = ARB_MODE != 0 ? rr_sel : slot_q;
    go    = ARB_MODE != 0 ? rr_vld : 1'b1;
    grant = ARB_MODE != 0 ? rr_vld : portReq[slot_q];
  end
  // access sequencer; TDM always runs a full period, unused slots just keep strobes high
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    slot_d  = slot_q;
    ptr_d   = ptr_q;
    g_d     = g_q;
    act_d   = act_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (go) begin
        state_d = ADDR;
        act_d   = grant;
        g_d     = sel;
        slot_d  = slot_q == PW'(NUM_PORTS-1) ? '0 : slot_q + 1'b1;
        if (grant) begin
          we_d    = portWe[sel];
          addr_d  = portAddr[sel*ADDR_W +: ADDR_W];
          wdata_d = portWData[sel*DATA_W +: DATA_W];
          ptr_d   = ARB_MODE != 0 ? sel : ptr_q;
        end
      end
      ADDR: begin
        state_d = STROBE;
        cnt_d   = '0;
      end
      STROBE: if (cnt_q == 4'(ACCESS_CYCLES-1)) begin
        state_d = RECOVER;
        if (act_q && !we_q) rdata_d[g_q*DATA_W +: DATA_W] = memData;
      end else cnt_d = cnt_q + 1'b1;
      default: state_d = IDLE;
    endcase
  end
  // state register with synchronous reset
  always_ff @(posedge memClk) begin
    if (sysRst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      slot_q  <= '0;
      ptr_q   <= PW'(NUM_PORTS-1);
      g_q     <= '0;
      act_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      slot_q  <= slot_d;
      ptr_q   <= ptr_d;
      g_q     <= g_d;
      act_q   <= act_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end
  assign memAddr    = addr_q;
  assign memReN     = !(state_q == STROBE && act_q && !we_q);
  assign memWeN     = !(state_q == STROBE && act_q && we_q);
  assign memData    = (act_q && we_q && state_q != IDLE) ? wdata_q : 'z;
  assign portAck    = (state_q == ADDR && act_q) ? NUM_PORTS'(1) << g_q : '0;
  assign portRValid = (state_q == RECOVER && act_q && !we_q) ? NUM_PORTS'(1) << g_q : '0;
  assign portRData  = rdata_q;
endmodule

// File: tb/tb_mp_sram_arbiter.sv
// tb_mp_sram_arbiter: scoreboard bench for RR, TDM and 8-port/16-bit configurations
module tb_mp_sram_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  int n_chk = 0, n_fail = 0;
  logic [15:0] a_addr; wire [7:0] a_data; logic a_ren, a_wen;
  logic [2:0] a_req = '0, a_we = '0, a_ack, a_rv;
  logic [47:0] a_pa = '0; logic [23:0] a_pw = '0, a_rd;
  logic a_tbdrv = 1'b0;
  logic [7:0] a_mem [0:65535];
  logic [15:0] b_addr; wire [7:0] b_data; logic b_ren, b_wen;
  logic [2:0] b_req = '0, b_we = '0, b_ack, b_rv;
  logic [47:0] b_pa = '0; logic [23:0] b_pw = '0, b_rd;
  logic b_tbdrv = 1'b0;
  logic [7:0] b_mem [0:65535];
  logic [15:0] c_addr; wire [15:0] c_data; logic c_ren, c_wen;
  logic [7:0] c_req = '0, c_we = '0, c_ack, c_rv;
  logic [127:0] c_pa = '0, c_pw = '0, c_rd;
  logic [15:0] c_mem [0:65535];
  int aq[$], arq[$], bq[$], cq[$], crq[$];
  mp_sram_arbiter #(.NUM_PORTS(3), .ADDR_W(16), .DATA_W(8), .ACCESS_CYCLES(2), .ARB_MODE(1)) u_a (
    .memClk(clk), .sysRst(rst), .memAddr(a_addr), .memData(a_data), .memReN(a_ren), .memWeN(a_wen),
    .portReq(a_req), .portWe(a_we), .portAddr(a_pa), .portWData(a_pw),
    .portAck(a_ack), .portRValid(a_rv), .portRData(a_rd));
  mp_sram_arbiter #(.NUM_PORTS(3), .ADDR_W(16), .DATA_W(8), .ACCESS_CYCLES(2), .ARB_MODE(0)) u_b (
    .memClk(clk), .sysRst(rst), .memAddr(b_addr), .memData(b_data), .memReN(b_ren), .memWeN(b_wen),
    .portReq(b_req), .portWe(b_we), .portAddr(b_pa), .portWData(b_pw),
    .portAck(b_ack), .portRValid(b_rv), .portRData(b_rd));
  mp_sram_arbiter #(.NUM_PORTS(8), .ADDR_W(16), .DATA_W(16), .ACCESS_CYCLES(1), .ARB_MODE(1)) u_c (
    .memClk(clk), .sysRst(rst), .memAddr(c_addr), .memData(c_data), .memReN(c_ren), .memWeN(c_wen),
    .portReq(c_req), .portWe(c_we), .portAddr(c_pa), .portWData(c_pw),
    .portAck(c_ack), .portRValid(c_rv), .portRData(c_rd));
  assign a_data = !a_ren ? a_mem[a_addr] : 8'bz;
  assign a_data = a_tbdrv ? 8'hC3 : 8'bz;
  assign b_data = !b_ren ? b_mem[b_addr] : 8'bz;
  assign b_data = b_tbdrv ? 8'hC3 : 8'bz;
  assign c_data = !c_ren ? c_mem[c_addr] : 16'bz;
  always @(posedge clk) if (!a_wen) a_mem[a_addr] <= a_data;
  always @(posedge clk) if (!b_wen) b_mem[b_addr] <= b_data;
  always @(posedge clk) if (!c_wen) c_mem[c_addr] <= c_data;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic do_reset();
    @(negedge clk) rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic wait_ack(input int d, input int p, output int cyc);
    logic [7:0] v;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      v = d == 0 ? 8'(a_ack) : d == 1 ? 8'(b_ack) : c_ack;
    end while (!v[p] && cyc < 100);
    if (!v[p]) chk("ack_timeout", 0, 1);
  endtask
  always @(negedge clk) begin : mon_a
    int e;
    chk("a_excl", 64'(a_ren | a_wen), 1);
    for (int p = 0; p < 3; p++) begin
      if (a_ack[p]) begin
        if (aq.size() == 0) chk("a_ack_unexp", p, 99);
        else chk("a_ack_port", p, aq.pop_front());
      end
      if (a_rv[p]) begin
        if (arq.size() == 0) chk("a_rv_unexp", p, 99);
        else begin
          e = arq.pop_front();
          chk("a_rv_port", p, e >> 16);
          chk("a_rv_data", a_rd[p*8 +: 8], e & 'hFFFF);
        end
      end
    end
  end
  always @(negedge clk) begin : mon_b
    chk("b_excl", 64'(b_ren | b_wen), 1);
    chk("b_rv_none", b_rv, 0);
    for (int p = 0; p < 3; p++)
      if (b_ack[p]) begin
        if (bq.size() == 0) chk("b_ack_unexp", p, 99);
        else chk("b_ack_port", p, bq.pop_front());
      end
  end
  always @(negedge clk) begin : mon_c
    int e;
    chk("c_excl", 64'(c_ren | c_wen), 1);
    for (int p = 0; p < 8; p++) begin
      if (c_ack[p]) begin
        if (cq.size() == 0) chk("c_ack_unexp", p, 99);
        else chk("c_ack_port", p, cq.pop_front());
      end
      if (c_rv[p]) begin
        if (crq.size() == 0) chk("c_rv_unexp", p, 99);
        else begin
          e = crq.pop_front();
          chk("c_rv_port", p, e >> 16);
          chk("c_rv_data", c_rd[p*16 +: 16], e & 'hFFFF);
        end
      end
    end
  end
  initial begin
    int cyc, n, last, t7;
    logic again;
    a_mem[16'h1234] = 8'hA5;
    a_mem[16'h0020] = 8'h42;
    for (int p = 0; p < 3; p++) a_mem[16'h0010 + p] = 8'h70 + 8'(p);
    for (int p = 0; p < 8; p++) c_mem[16'h0100 + p] = 16'hBEE0 + 16'(p) * 16'h0111;
    c_mem[16'h0200] = 16'h1357;
    repeat (3) @(negedge clk);
    chk("rst_addr", a_addr, 0);
    chk("rst_ren", a_ren, 1);
    chk("rst_wen", a_wen, 1);
    chk("rst_ack", a_ack, 0);
    chk("rst_rv", a_rv, 0);
    chk("rst_rdata", a_rd, 0);
    chk("rst_c_rdata", c_rd, 0);
    rst = 1'b0;
    // reset in the middle of a write
    a_req = 3'b001; a_we = 3'b001; a_pa[15:0] = 16'h0500; a_pw[7:0] = 8'h77;
    aq.push_back(0);
    wait_ack(0, 0, cyc);
    a_req = '0;
    @(negedge clk);
    chk("mid_wr_wen", a_wen, 0);
    rst = 1'b1;
    @(posedge clk);
    #1 a_tbdrv = 1'b1;
    @(negedge clk);
    chk("rst_mid_wen", a_wen, 1);
    chk("rst_mid_ren", a_ren, 1);
    chk("rst_mid_release", a_data, 8'hC3);
    a_tbdrv = 1'b0;
    rst = 1'b0;
    a_we = '0;
    repeat (8) begin
      @(negedge clk);
      chk("rst_no_ack", a_ack, 0);
      chk("rst_no_rv", a_rv, 0);
    end
    // single read on port 1, then port 0 back-to-back
    a_req = 3'b010; a_pa[31:16] = 16'h1234;
    aq.push_back(1); arq.push_back((1 << 16) | 'hA5);
    wait_ack(0, 1, cyc);
    chk("rd_ack_lat", cyc, 1);
    a_req = 3'b001; a_pa[15:0] = 16'h0020;
    aq.push_back(0); arq.push_back('h42);
    @(negedge clk) chk("rd_ren_s1", a_ren, 0);
    @(negedge clk) chk("rd_ren_s2", a_ren, 0);
    @(negedge clk) chk("rd_ren_rec", a_ren, 1);
    chk("rd_rvalid", a_rv, 3'b010);
    chk("rd_data", a_rd[15:8], 8'hA5);
    wait_ack(0, 0, cyc);
    chk("rd_gap", cyc + 3, 5);
    a_req = '0;
    repeat (6) @(negedge clk);
    // round-robin fairness with all ports requesting
    do_reset();
    for (int p = 0; p < 3; p++) a_pa[p*16 +: 16] = 16'h0010 + 16'(p);
    for (int k = 0; k < 6; k++) begin
      aq.push_back(k % 3);
      arq.push_back(((k % 3) << 16) | (8'h70 + (k % 3)));
    end
    a_req = 3'b111;
    n = 0; last = 0; cyc = 0;
    while (n < 6 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (|a_ack) begin
        n++;
        if (n > 1) chk("rr_gap", cyc - last, 5);
        last = cyc;
      end
    end
    chk("rr_count", n, 6);
    a_req = '0;
    repeat (6) @(negedge clk);
    // write then read of the same address
    a_we = 3'b001; a_pa[15:0] = 16'h00FF; a_pw[7:0] = 8'h3C; a_pa[31:16] = 16'h00FF;
    aq.push_back(0); aq.push_back(1); arq.push_back((1 << 16) | 'h3C);
    a_req = 3'b011;
    cyc = 0;
    while (a_req != 0 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (a_ack[0]) a_req[0] = 1'b0;
      if (a_ack[1]) a_req[1] = 1'b0;
    end
    chk("wr_rd_done", a_req, 0);
    repeat (6) @(negedge clk);
    chk("wr_rd_mem", a_mem[16'h00FF], 8'h3C);
    chk("wr_rd_lane", a_rd[15:8], 8'h3C);
    a_we = '0;
    // TDM: only port 2 writes, granted in third slot
    do_reset();
    b_req = 3'b100; b_we = 3'b100; b_pa[47:32] = 16'h0040; b_pw[23:16] = 8'h5A;
    bq.push_back(2);
    cyc = 0;
    while (cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (b_ack[2]) break;
      chk("tdm_idle_strb", {b_ren, b_wen}, 2'b11);
    end
    chk("tdm_slot", cyc, 11);
    b_req = '0;
    chk("tdm_addr", b_addr, 16'h0040);
    chk("tdm_d_addr", b_data, 8'h5A);
    @(negedge clk) chk("tdm_wen1", b_wen, 0);
    chk("tdm_d1", b_data, 8'h5A);
    @(negedge clk) chk("tdm_wen2", b_wen, 0);
    @(negedge clk) chk("tdm_wen_rec", b_wen, 1);
    chk("tdm_d_rec", b_data, 8'h5A);
    @(posedge clk);
    #1 b_tbdrv = 1'b1;
    @(negedge clk) chk("tdm_release", b_data, 8'hC3);
    b_tbdrv = 1'b0;
    chk("tdm_mem", b_mem[16'h0040], 8'h5A);
    // 8 ports, 16-bit data, wrap from port 7 back to port 0
    do_reset();
    for (int p = 0; p < 8; p++) begin
      c_pa[p*16 +: 16] = 16'h0100 + 16'(p);
      cq.push_back(p);
      crq.push_back((p << 16) | (16'hBEE0 + p * 16'h0111));
    end
    cq.push_back(0); crq.push_back('h1357);
    c_req = 8'hFF;
    n = 0; cyc = 0; again = 1'b0; t7 = 0;
    while (n < 9 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      for (int p = 0; p < 8; p++)
        if (c_ack[p]) begin
          n++;
          if (p == 7) t7 = cyc;
          if (p == 0 && !again) begin
            again = 1'b1;
            c_pa[15:0] = 16'h0200;
          end else c_req[p] = 1'b0;
          if (p == 0 && n == 9) chk("c_wrap_gap", cyc - t7, 4);
        end
    end
    chk("c_count", n, 9);
    c_req = '0;
    repeat (8) @(negedge clk);
    chk("c_lane0", c_rd[15:0], 16'h1357);
    for (int p = 1; p < 8; p++) chk("c_lane", c_rd[p*16 +: 16], 16'hBEE0 + 16'(p) * 16'h0111);
    chk("a_q_empty", aq.size() + arq.size(), 0);
    chk("b_q_empty", bq.size(), 0);
    chk("c_q_empty", cq.size() + crq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mp_sram_arbiter.md
Name: mp_sram_arbiter

Overview:
- Parametrised multi-port adaptor. Time-shares one asynchronous external SRAM (single shared data bus) among NUM_PORTS clients, for example CPU, VGA scan-out and DMA.
- Successor to the fixed two-client, four-phase adaptor. Adds:
  - any number of ports;
  - configurable address and data widths;
  - programmable strobe length;
  - two arbitration modes: fixed TDM slots for deterministic video bandwidth, or work-conserving round-robin;
  - a per-port req/ack/rvalid handshake.
- Sits between the bus clients and the SRAM pins.

Parameters:
- NUM_PORTS, 2: number of client ports (2..8).
- ADDR_W, 16: SRAM and port address width.
- DATA_W, 8: SRAM and port data width.
- ACCESS_CYCLES, 1: memClk cycles the read/write strobe is held low (1..15).
- ARB_MODE, 0: 0 = fixed TDM slots, 1 = round-robin over requesting ports.

Ports:
- memClk  in  1  system memory clock; all logic on rising edge.
- sysRst  in  1  synchronous reset, active high.
- memAddr  out  ADDR_W  SRAM address.
- memData  inout  DATA_W  SRAM data bus.
- memReN  out  1  SRAM output enable, active low.
- memWeN  out  1  SRAM write enable, active low.
- portReq  in  NUM_PORTS  per-port access request.
- portWe  in  NUM_PORTS  per-port write (1) / read (0).
- portAddr  in  NUM_PORTS*ADDR_W  per-port address; port i at bits [i*ADDR_W +: ADDR_W].
- portWData  in  NUM_PORTS*DATA_W  per-port write data.
- portAck  out  NUM_PORTS  one-cycle pulse: command captured.
- portRValid  out  NUM_PORTS  one-cycle pulse: portRData valid.
- portRData  out  NUM_PORTS*DATA_W  per-port registered read data; holds its value until the port's next read completes.

Behaviour:
- Clock and reset: one clock, memClk. Reset sysRst is synchronous, active high.
- Reset values:
  - memReN=1, memWeN=1, memAddr=0, memData hi-Z;
  - portAck=0, portRValid=0, portRData=0;
  - state=IDLE, TDM slot=0, RR last-grant pointer=NUM_PORTS-1 (so port 0 wins first).
- FSM: IDLE -> ADDR (1 cycle) -> STROBE (ACCESS_CYCLES cycles) -> RECOVER (1 cycle) -> IDLE (at least 1 cycle).
  - Access period P = ACCESS_CYCLES+3 cycles.
- IDLE, grant selection:
  - ARB_MODE=0: the only candidate is port[slot]. If portReq[slot]=1 it is granted. If not, the slot is spent idle for P cycles with strobes high. slot increments modulo NUM_PORTS every P cycles, whether the slot was used or not.
  - ARB_MODE=1: the first requesting port searching from pointer+1 with wrap-around. If no port is requesting, stay in IDLE and grant nothing. Pointer updates to the granted port.
- Grant edge: the rising edge leaving IDLE with a grant.
  - Capture that port's we, addr and wdata into internal registers.
  - portAck[g]=1 for exactly the ADDR cycle.
  - The client must hold req/we/addr/wdata stable until it sees ack. It may change or drop them from the following edge.
- ADDR: memAddr=captured addr; memReN=1, memWeN=1. For a write, memData is driven with wdata.
- STROBE:
  - read: memReN=0, memData hi-Z;
  - write: memWeN=0, memData driven.
- End of read: memData is sampled on the rising edge that ends the last STROBE cycle, into portRData[g]. portRValid[g]=1 during RECOVER, one cycle.
- RECOVER: both strobes high; memAddr held. For a write, memData is still driven (hold time). memData is released in IDLE.
- Outside STROBE both strobes are high. memReN and memWeN are never low together. memData is driven only for a write from ADDR through RECOVER.
- Latency: for a read granted at edge E, portRValid is high in cycle E+ACCESS_CYCLES+1 (counting the ADDR cycle as E).
- Outstanding accesses: at most one per port. A port's req seen while that port is mid-access is not granted until the next IDLE.
- Simultaneous requests in RR mode: exactly one grant per period. Every continuously requesting port is served within NUM_PORTS periods.
- Reset mid-access:
  - at the next edge, strobes go high and memData is released;
  - no pending ack or rvalid is issued;
  - clients must re-request.
- Address and data are passed through unchanged; no width arithmetic. Slot and pointer counters wrap at NUM_PORTS-1 -> 0.

Test Plan:
- Reset: NUM_PORTS=3, ACCESS_CYCLES=2, ARB_MODE=1; assert sysRst mid-write -> next cycle memWeN=1, memReN=1, memData=Z; all ack/rvalid stay 0.
- RR single read: port1 reads 0x1234 (SRAM model holds 0xA5) -> portAck[1] pulse in ADDR; memReN low for 2 cycles; portRData[1]=0xA5; portRValid[1] pulses 3 cycles after ack; next grant no earlier than 5 cycles after ack.
- RR fairness: all 3 ports request continuously -> grant order 0,1,2,0,1,2; one grant every 5 cycles; no port starves.
- TDM, ARB_MODE=0: only port2 requests, write 0x5A to 0x0040 -> ack only in slot 2 (third period); slots 0 and 1 idle with strobes high; SRAM model holds 0x5A at 0x0040; memData stable through RECOVER.
- Write-then-read ordering: port0 writes 0x3C at 0x00FF, then port1 reads 0x00FF in the next period -> portRData[1]=0x3C; memWeN and memReN never low together.
- Params NUM_PORTS=8, DATA_W=16, ACCESS_CYCLES=1: all ports read distinct addresses -> each portRData lane gets the correct 16-bit word; wrap from port 7 to port 0.
